// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Width codes, FSM state encoding and request legality check.
package lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RESP,
        ERR
    } state_e;

    // Stores have no unsigned variants.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response bundle and memory-side pin bundle
// of the load/store unit.
interface lsu_req_if;
    import lsu_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface lsu_mem_if;
    import lsu_pkg::*;

    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Lane extraction with sign/zero extension for loads and
// byte/halfword merge into a fetched word for stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] word_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] load_o,
    output logic [XLEN-1:0] store_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        load_o   = word_i;
        store_o  = wdata_i;
        case (funct3_i)
            F3_B: begin
                load_o  = {{24{byte_sel[7]}}, byte_sel};
                store_o = word_i;
                store_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            F3_H: begin
                load_o  = {{16{half_sel[15]}}, half_sel};
                store_o = off_i[1] ? {wdata_i[15:0], word_i[15:0]}
                                   : {word_i[31:16], wdata_i[15:0]};
            end
            F3_BU:   load_o = {24'h0, byte_sel};
            F3_HU:   load_o = {16'h0, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between execute and memory access; sole driver of memory pins.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    state_e          state_q;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [XLEN-1:0] wdata_q;

    logic            rsp_valid_q;
    logic            rsp_err_q;
    logic [XLEN-1:0] rsp_rdata_q;
    logic            mem_we_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;

    logic [XLEN-1:0] ld_ext;
    logic [XLEN-1:0] st_word;
    logic            bad;

    lsu_align u_align (
        .funct3_i (f3_q),
        .off_i    (off_q),
        .word_i   (mem.mem_rdata),
        .wdata_i  (wdata_q),
        .load_o   (ld_ext),
        .store_o  (st_word)
    );

    always_comb begin
        bad = !f3_legal(req.req_we, req.req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        if (req.req_funct3[1:0] == 2'b01 && req.req_addr[0])
            bad = 1'b1;
        if (req.req_funct3 == F3_W && req.req_addr[1:0] != 2'b00)
            bad = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            unique case (state_q)
                IDLE: if (req.req_valid) begin
                    we_q    <= req.req_we;
                    f3_q    <= req.req_funct3;
                    off_q   <= req.req_addr[1:0];
                    wdata_q <= req.req_wdata;
                    if (bad) begin
                        state_q     <= ERR;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end else if (req.req_we && req.req_funct3 == F3_W) begin
                        state_q     <= WRITE;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {req.req_addr[31:2], 2'b00};
                        mem_wdata_q <= req.req_wdata;
                    end else begin
                        state_q    <= READ;
                        mem_addr_q <= {req.req_addr[31:2], 2'b00};
                    end
                end
                // Sub-word stores merge into the word being read this cycle.
                READ: if (we_q) begin
                    state_q     <= WRITE;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= mem_addr_q;
                    mem_wdata_q <= st_word;
                end else begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= ld_ext;
                end
                WRITE: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                RESP:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req.req_ready = (state_q == IDLE);
    assign req.rsp_valid = rsp_valid_q;
    assign req.rsp_err   = rsp_err_q;
    assign req.rsp_rdata = rsp_rdata_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule
